// File: rtl/mcp3201_emu.sv
// mcp3201_emu: MCP3201 ADC emulator acting as SPI responder.
// SCLK and CS# are resynchronised into the system clock domain. Each CS# fall
// snapshots the staging register. Each SCLK fall then advances the frame
// counter and drives the next MCP3201 framing bit on every channel's MISO:
// two sample-period highs, a null bit, B11..B0, then B1..B11.
module mcp3201_emu #(
  parameter int CHANNELS    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   spi_clk_i,
  input  logic                   spi_ssn_i,
  output logic [CHANNELS-1:0]    spi_miso_o,
  output logic                   spi_miso_oe_o,
  input  logic [CHANNELS*12-1:0] data_i,
  input  logic                   strb_i,
  output logic                   conv_o,
  output logic                   done_o,
  output logic                   short_o,
  output logic                   fsm_state_o
);

  localparam int         W        = CHANNELS * 12;
  localparam logic [4:0] CNT_MAX  = 5'd27;
  localparam logic [4:0] CNT_DONE = 5'd15;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Input synchronisers. Bit SYNC_STAGES-1 is the synchronised level.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ssn_sync;
  logic                   sclk_dly;
  logic                   ssn_dly;
  logic                   sclk_s;
  logic                   ssn_s;
  logic                   sclk_fall;
  logic                   ssn_fall;
  logic                   ssn_rise;

  // Sample storage: staging is written by strb_i; snap is frozen for one frame.
  logic [W-1:0] staging;
  logic [W-1:0] snap;
  logic [W-1:0] snap_src;

  // Frame counter and registered outputs.
  logic [4:0]          fall_cnt;
  logic [4:0]          cnt_nxt;
  logic [4:0]          cnt_inc;
  logic [CHANNELS-1:0] miso_q;
  logic [CHANNELS-1:0] miso_nxt;
  logic                oe_q;
  logic                oe_nxt;
  logic                conv_nxt;
  logic                done_nxt;
  logic                short_nxt;
  logic                snap_load;

  // Bit driven on MISO once the frame counter has reached n.
  function automatic logic frame_bit(input logic [11:0] w, input logic [4:0] n);
    logic [3:0] idx;
    logic       b;
    idx = 4'd0;
    b   = 1'b0;
    if (n == 5'd1 || n == 5'd2) begin
      b = 1'b1;
    end else if (n >= 5'd4 && n <= 5'd15) begin
      idx = 4'(5'd15 - n);
      b   = w[idx];
    end else if (n >= 5'd16 && n <= 5'd26) begin
      idx = 4'(n - 5'd15);
      b   = w[idx];
    end
    return b;
  endfunction

  // Synchronise SCLK/CS#, with one extra delay stage for edge detection.
  // Reset presets every stage to the idle-high level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync <= '1;
      ssn_sync  <= '1;
      sclk_dly  <= 1'b1;
      ssn_dly   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], spi_ssn_i};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
      ssn_dly   <= ssn_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_dly & ~sclk_s;
  assign ssn_fall  = ssn_dly & ~ssn_s;
  assign ssn_rise  = ~ssn_dly & ssn_s;

  // Staging register follows strb_i regardless of the SPI state.
  always_ff @(posedge clock) begin
    if (reset) begin
      staging <= '0;
    end else if (strb_i) begin
      staging <= data_i;
    end
  end

  // A strobe in the same cycle as the CS# fall bypasses staging.
  assign snap_src = strb_i ? data_i : staging;

  // The counter saturates at 27 so long frames keep shifting zeros.
  assign cnt_inc = (fall_cnt >= CNT_MAX) ? CNT_MAX : fall_cnt + 5'd1;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: CS# fall opens a frame and CS# rise closes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ssn_fall) state_nxt = FRAME;
      FRAME:   if (ssn_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: next values for the counter, MISO, OE and the status pulses.
  // In FRAME, a CS# rise takes priority over an SCLK fall in the same cycle.
  always_comb begin
    cnt_nxt   = fall_cnt;
    miso_nxt  = miso_q;
    oe_nxt    = oe_q;
    conv_nxt  = 1'b0;
    done_nxt  = 1'b0;
    short_nxt = 1'b0;
    snap_load = 1'b0;
    case (state)
      IDLE: begin
        oe_nxt   = 1'b0;
        miso_nxt = '1;
        if (ssn_fall) begin
          snap_load = 1'b1;
          cnt_nxt   = 5'd0;
          conv_nxt  = 1'b1;
          oe_nxt    = 1'b1;
        end
      end
      FRAME: begin
        if (ssn_rise) begin
          oe_nxt   = 1'b0;
          miso_nxt = '1;
          if (fall_cnt >= CNT_DONE) begin
            done_nxt = 1'b1;
          end else begin
            short_nxt = 1'b1;
          end
        end else if (sclk_fall) begin
          cnt_nxt = cnt_inc;
          for (int i = 0; i < CHANNELS; i++) begin
            miso_nxt[i] = frame_bit(snap[i*12 +: 12], cnt_inc);
          end
        end
      end
      default: begin
        oe_nxt   = 1'b0;
        miso_nxt = '1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fall_cnt <= 5'd0;
      snap     <= '0;
      miso_q   <= '1;
      oe_q     <= 1'b0;
      conv_o   <= 1'b0;
      done_o   <= 1'b0;
      short_o  <= 1'b0;
    end else begin
      fall_cnt <= cnt_nxt;
      if (snap_load) begin
        snap <= snap_src;
      end
      miso_q   <= miso_nxt;
      oe_q     <= oe_nxt;
      conv_o   <= conv_nxt;
      done_o   <= done_nxt;
      short_o  <= short_nxt;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign fsm_state_o   = (state == FRAME);

endmodule

// File: tb/tb_mcp3201_emu.sv
// tb_mcp3201_emu: directed bench for the MCP3201 emulator.
// Uses a two-channel instance with a 12:1 system-clock to SCLK ratio.
module tb_mcp3201_emu;

  localparam int CH   = 2;
  localparam int SS   = 2;
  localparam int HALF = 6;

  // ---------------- clock / reset ----------------
  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic spi_clk_i = 1'b1;
  logic spi_ssn_i = 1'b1;
  logic strb_i    = 1'b0;
  logic [CH*12-1:0] data_i = '0;
  logic [CH-1:0]    spi_miso_o;
  logic             spi_miso_oe_o;
  logic             conv_o;
  logic             done_o;
  logic             short_o;
  logic             fsm_state_o;

  always #5 clock = ~clock;

  mcp3201_emu #(.CHANNELS(CH), .SYNC_STAGES(SS)) dut (
    .clock         (clock),
    .reset         (reset),
    .spi_clk_i     (spi_clk_i),
    .spi_ssn_i     (spi_ssn_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .data_i        (data_i),
    .strb_i        (strb_i),
    .conv_o        (conv_o),
    .done_o        (done_o),
    .short_o       (short_o),
    .fsm_state_o   (fsm_state_o)
  );

  // ---------------- scoreboard state ----------------
  int checks    = 0;
  int errors    = 0;
  int conv_cnt  = 0;
  int done_cnt  = 0;
  int short_cnt = 0;
  int oe_bad    = 0;
  logic [CH-1:0] rd [1:40];
  logic [11:0]   exp_q [$];

  // Count every cycle each pulse output is high; a stuck pulse counts more than once.
  always @(negedge clock) begin
    if (conv_o)  conv_cnt++;
    if (done_o)  done_cnt++;
    if (short_o) short_cnt++;
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [CH*12-1:0] d);
    data_i = d;
    strb_i = 1'b1;
    tick(1);
    strb_i = 1'b0;
    data_i = '0;
  endtask

  // n SCLK periods; MISO is captured just before each rising edge.
  // Optionally strobe mid_d into staging during fall number mid_k.
  task automatic falls(input int n, input int mid_k, input logic [CH*12-1:0] mid_d);
    tick(HALF);
    for (int k = 1; k <= n; k++) begin
      spi_clk_i = 1'b0;
      if (k == mid_k) begin
        data_i = mid_d;
        strb_i = 1'b1;
        tick(1);
        strb_i = 1'b0;
        data_i = '0;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      rd[k] = spi_miso_o;
      if (!spi_miso_oe_o) oe_bad++;
      spi_clk_i = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic end_frame(input string name);
    int i;
    spi_ssn_i = 1'b1;
    i = 0;
    while (spi_miso_oe_o && i < SS + 2) begin
      tick(1);
      i++;
    end
    check({name, " oe_off"}, spi_miso_oe_o, 0);
    tick(4);
    check({name, " miso_idle"}, spi_miso_o, 2'b11);
  endtask

  task automatic check_read(input string name, input logic [11:0] w0, input logic [11:0] w1);
    logic [11:0] g0;
    logic [11:0] g1;
    check({name, " pre_ch0"}, {rd[1][0], rd[2][0], rd[3][0]}, 3'b110);
    check({name, " pre_ch1"}, {rd[1][1], rd[2][1], rd[3][1]}, 3'b110);
    g0 = '0;
    g1 = '0;
    for (int k = 4; k <= 15; k++) begin
      g0 = {g0[10:0], rd[k][0]};
      g1 = {g1[10:0], rd[k][1]};
    end
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    check({name, " word_ch0"}, g0, exp_q.pop_front());
    check({name, " word_ch1"}, g1, exp_q.pop_front());
  endtask

  task automatic check_counts(input string name, input int c0, input int d0, input int s0,
                              input logic exp_done);
    check({name, " conv"}, conv_cnt - c0, 1);
    check({name, " done"}, done_cnt - d0, {31'd0, exp_done});
    check({name, " short"}, short_cnt - s0, {31'd0, ~exp_done});
    check({name, " oe_in_frame"}, oe_bad, 0);
  endtask

  task automatic run_frame(input string name, input int n, input logic [CH*12-1:0] d,
                           input logic exp_done, input logic [11:0] w0, input logic [11:0] w1);
    int c0;
    int d0;
    int s0;
    c0 = conv_cnt;
    d0 = done_cnt;
    s0 = short_cnt;
    oe_bad = 0;
    load(d);
    spi_ssn_i = 1'b0;
    falls(n, 0, '0);
    end_frame(name);
    check_counts(name, c0, d0, s0, exp_done);
    if (n >= 15) check_read(name, w0, w1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    logic [23:0] data;
    int          n;
    logic        done;
    logic [11:0] w0;
    logic [11:0] w1;
    logic [10:0] t0;
    logic [10:0] t1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0;
    int d0;
    int s0;
    logic [10:0] g0;
    logic [10:0] g1;
    logic [7:0]  z;

    vecs[0] = '{"ch_fff_001", {12'h001, 12'hFFF}, 15, 1'b1, 12'hFFF, 12'h001, 11'h0, 11'h0};
    vecs[1] = '{"a5c",        {12'h000, 12'hA5C}, 15, 1'b1, 12'hA5C, 12'h000, 11'h0, 11'h0};
    vecs[2] = '{"long_801",   {12'h5A3, 12'h801}, 30, 1'b1, 12'h801, 12'h5A3, 11'h001, 11'h45A};
    vecs[3] = '{"short_8",    {12'h123, 12'h456},  8, 1'b0, 12'h0,   12'h0,   11'h0, 11'h0};
    vecs[4] = '{"short_14",   {12'hABC, 12'hDEF}, 14, 1'b0, 12'h0,   12'h0,   11'h0, 11'h0};
    vecs[5] = '{"done_16",    {12'h5A5, 12'h3C3}, 16, 1'b1, 12'h3C3, 12'h5A5, 11'h0, 11'h0};

    // Reset state
    tick(3);
    check("rst miso", spi_miso_o, 2'b11);
    check("rst oe", spi_miso_oe_o, 0);
    check("rst conv", conv_o, 0);
    check("rst done", done_o, 0);
    check("rst short", short_o, 0);
    check("rst state", fsm_state_o, 0);
    reset = 1'b0;
    tick(4);

    // SCLK activity with CS# high is ignored
    c0 = conv_cnt;
    for (int k = 0; k < 3; k++) begin
      spi_clk_i = 1'b0;
      tick(HALF);
      spi_clk_i = 1'b1;
      tick(HALF);
    end
    check("idle_sclk oe", spi_miso_oe_o, 0);
    check("idle_sclk state", fsm_state_o, 0);
    check("idle_sclk conv", conv_cnt - c0, 0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].name, vecs[i].n, vecs[i].data, vecs[i].done, vecs[i].w0, vecs[i].w1);
      if (vecs[i].n >= 30) begin
        g0 = '0;
        g1 = '0;
        for (int k = 16; k <= 26; k++) begin
          g0 = {g0[9:0], rd[k][0]};
          g1 = {g1[9:0], rd[k][1]};
        end
        check({vecs[i].name, " tail_ch0"}, g0, vecs[i].t0);
        check({vecs[i].name, " tail_ch1"}, g1, vecs[i].t1);
        z = {rd[27], rd[28], rd[29], rd[30]};
        check({vecs[i].name, " after_26"}, z, 8'h00);
      end
      tick(5);
    end

    // Strobe in the same cycle as the internal CS# fall event
    load({12'h111, 12'h111});
    c0 = conv_cnt;
    d0 = done_cnt;
    s0 = short_cnt;
    oe_bad = 0;
    spi_ssn_i = 1'b0;
    tick(SS);
    data_i = {12'h123, 12'h123};
    strb_i = 1'b1;
    tick(1);
    strb_i = 1'b0;
    data_i = '0;
    check("strb_evt conv_now", conv_o, 1);
    falls(15, 0, '0);
    end_frame("strb_evt");
    check_counts("strb_evt", c0, d0, s0, 1'b1);
    check_read("strb_evt", 12'h123, 12'h123);
    tick(5);

    // Strobe during FRAME affects only the next frame
    c0 = conv_cnt;
    d0 = done_cnt;
    s0 = short_cnt;
    oe_bad = 0;
    spi_ssn_i = 1'b0;
    falls(15, 5, {12'h456, 12'h456});
    end_frame("strb_mid");
    check_counts("strb_mid", c0, d0, s0, 1'b1);
    check_read("strb_mid", 12'h123, 12'h123);
    tick(5);
    c0 = conv_cnt;
    d0 = done_cnt;
    s0 = short_cnt;
    oe_bad = 0;
    spi_ssn_i = 1'b0;
    falls(15, 0, '0);
    end_frame("strb_next");
    check_counts("strb_next", c0, d0, s0, 1'b1);
    check_read("strb_next", 12'h456, 12'h456);
    tick(5);

    // CS# fall and SCLK fall together: SCLK edge ignored
    load({12'h9E1, 12'h9E1});
    c0 = conv_cnt;
    d0 = done_cnt;
    s0 = short_cnt;
    oe_bad = 0;
    spi_ssn_i = 1'b0;
    spi_clk_i = 1'b0;
    tick(HALF);
    spi_clk_i = 1'b1;
    falls(15, 0, '0);
    end_frame("cs_sclk_fall");
    check_counts("cs_sclk_fall", c0, d0, s0, 1'b1);
    check_read("cs_sclk_fall", 12'h9E1, 12'h9E1);
    tick(5);

    // CS# rise and SCLK fall together after 14 falls: no shift, short frame
    load({12'h777, 12'h777});
    c0 = conv_cnt;
    d0 = done_cnt;
    s0 = short_cnt;
    oe_bad = 0;
    spi_ssn_i = 1'b0;
    falls(14, 0, '0);
    spi_clk_i = 1'b0;
    spi_ssn_i = 1'b1;
    tick(SS + 4);
    spi_clk_i = 1'b1;
    tick(HALF);
    check_counts("cs_rise_sclk", c0, d0, s0, 1'b0);
    check("cs_rise_sclk oe", spi_miso_oe_o, 0);
    tick(5);

    // Reset mid-frame at fall_cnt = 7
    load({12'h3C6, 12'h3C6});
    spi_ssn_i = 1'b0;
    falls(7, 0, '0);
    d0 = done_cnt;
    s0 = short_cnt;
    reset = 1'b1;
    spi_ssn_i = 1'b1;
    tick(1);
    check("mid_rst oe", spi_miso_oe_o, 0);
    check("mid_rst miso", spi_miso_o, 2'b11);
    check("mid_rst state", fsm_state_o, 0);
    reset = 1'b0;
    tick(10);
    check("mid_rst no_done", done_cnt - d0, 0);
    check("mid_rst no_short", short_cnt - s0, 0);
    run_frame("post_rst", 15, {12'h3C6, 12'h3C6}, 1'b1, 12'h3C6, 12'h3C6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
